// File: rtl/sik_stack_if.sv
// Request/response bundle between decode (master) and the operand-stack unit (slave).
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready; rsp_valid pulses one cycle later.
interface sik_stack_if #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 256,
  parameter int THREADS = 2
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(THREADS) | 1;

  logic               req_valid;
  logic               req_ready;
  logic [TW-1:0]      req_thread;
  logic [2:0]         req_op;
  logic [11:0]        req_arg;
  logic [WIDTH-1:0]   req_data;

  logic               rsp_valid;
  logic [TW-1:0]      rsp_thread;
  logic [WIDTH-1:0]   rsp_tos;
  logic [WIDTH-1:0]   rsp_nos;
  logic [CW-1:0]      rsp_depth;
  logic               rsp_err;
  logic [THREADS-1:0] err_sticky;

  modport master (
    output req_valid, req_thread, req_op, req_arg, req_data,
    input  req_ready, rsp_valid, rsp_thread, rsp_tos, rsp_nos, rsp_depth, rsp_err, err_sticky
  );

  modport slave (
    input  req_valid, req_thread, req_op, req_arg, req_data,
    output req_ready, rsp_valid, rsp_thread, rsp_tos, rsp_nos, rsp_depth, rsp_err, err_sticky
  );
endinterface

// File: rtl/sik_stack_unit.sv
// Multithreaded operand-stack store with bounds checks and post-op TOS/NOS readback.
// Optional SIK_STACK_ZEROFILL_EN: clears every entry after reset before accepting requests.
module sik_stack_unit #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 256,
  parameter int THREADS = 2
) (
  input  logic           clk,
  input  logic           reset,
  sik_stack_if.slave     bus,
  output logic           dbg_state
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(THREADS) | 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_DUP, OP_GET, OP_PUT, OP_REPL2, OP_REPL1
  } op_t;

  typedef enum logic {S_RUN = 1'b0, S_INIT = 1'b1} state_t;

  logic [WIDTH-1:0] mem [THREADS][DEPTH];
  logic [CW-1:0]    cnt [THREADS];
  state_t           state;

  logic             accept;
  logic             thr_ok;
  logic [TW-1:0]    thr;
  logic             ok;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] tos_v;
  logic [WIDTH-1:0] nos_v;
  int unsigned      c, n, nn, new_c, wr_i;

  assign accept    = bus.req_valid & bus.req_ready;
  assign thr_ok    = int'(bus.req_thread) < THREADS;
  assign thr       = thr_ok ? bus.req_thread : '0;
  assign dbg_state = state;

  // Post-op TOS/NOS are read with the current op's write forwarded, so the
  // response and the next same-thread op both see the updated stack.
  always_comb begin
    c       = 32'(cnt[thr]);
    n       = 32'(bus.req_arg);
    nn      = 0;
    ok      = 1'b1;
    wr_en   = 1'b0;
    wr_i    = 0;
    wr_data = '0;
    new_c   = c;
    case (op_t'(bus.req_op))
      OP_PUSH: begin
        if (c == DEPTH) ok = 1'b0;
        else begin
          wr_en = 1'b1; wr_i = c; wr_data = bus.req_data; new_c = c + 1;
        end
      end
      OP_POP: begin
        if (n > c) ok = 1'b0;
        else new_c = c - n;
      end
      OP_DUP, OP_GET: begin
        nn = (op_t'(bus.req_op) == OP_DUP) ? 0 : n;
        if (nn >= c || c == DEPTH) ok = 1'b0;
        else begin
          wr_en = 1'b1; wr_i = c; wr_data = mem[thr][AW'(c - 1 - nn)]; new_c = c + 1;
        end
      end
      OP_PUT: begin
        if (n >= c) ok = 1'b0;
        else begin
          wr_en = 1'b1; wr_i = c - 1 - n; wr_data = mem[thr][AW'(c - 1)];
        end
      end
      OP_REPL2: begin
        if (c < 2) ok = 1'b0;
        else begin
          wr_en = 1'b1; wr_i = c - 2; wr_data = bus.req_data; new_c = c - 1;
        end
      end
      OP_REPL1: begin
        if (c < 1) ok = 1'b0;
        else begin
          wr_en = 1'b1; wr_i = c - 1; wr_data = bus.req_data;
        end
      end
      default: ;
    endcase
    if (!thr_ok) ok = 1'b0;
    if (!ok) begin
      wr_en = 1'b0;
      new_c = c;
    end

    tos_v = '0;
    nos_v = '0;
    if (new_c >= 1) begin
      if (wr_en && wr_i == new_c - 1) tos_v = wr_data;
      else tos_v = mem[thr][AW'(new_c - 1)];
    end
    if (new_c >= 2) begin
      if (wr_en && wr_i == new_c - 2) nos_v = wr_data;
      else nos_v = mem[thr][AW'(new_c - 2)];
    end
  end

`ifdef SIK_STACK_ZEROFILL_EN
  logic [AW-1:0] init_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_INIT;
      init_idx      <= '0;
      bus.req_ready <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == AW'(DEPTH - 1)) begin
            state         <= S_RUN;
            bus.req_ready <= 1'b1;
          end
        end
        default: bus.req_ready <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int t = 0; t < THREADS; t++) begin
      if (state == S_INIT) mem[t][init_idx] <= '0;
      else if (accept && wr_en && int'(thr) == t) mem[t][AW'(wr_i)] <= wr_data;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_RUN;
      bus.req_ready <= 1'b1;
    end else begin
      state         <= S_RUN;
      bus.req_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int t = 0; t < THREADS; t++) begin
      if (accept && wr_en && int'(thr) == t) mem[t][AW'(wr_i)] <= wr_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < THREADS; t++) cnt[t] <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_thread <= '0;
      bus.rsp_tos    <= '0;
      bus.rsp_nos    <= '0;
      bus.rsp_depth  <= '0;
      bus.rsp_err    <= 1'b0;
      bus.err_sticky <= '0;
    end else begin
      bus.rsp_valid <= accept;
      if (accept) begin
        bus.rsp_thread <= bus.req_thread;
        bus.rsp_err    <= !ok;
        bus.rsp_tos    <= thr_ok ? tos_v : '0;
        bus.rsp_nos    <= thr_ok ? nos_v : '0;
        bus.rsp_depth  <= thr_ok ? CW'(new_c) : '0;
        if (ok) cnt[thr] <= CW'(new_c);
        else if (thr_ok) bus.err_sticky[thr] <= 1'b1;
      end
    end
  end
endmodule
